// File: rtl/ncc_pkg.sv
// Shared types and sizing constants for the NCC grid controller.
package ncc_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DESC_LOAD  = 2'd1,
    WIN_STREAM = 2'd2,
    DONE       = 2'd3
  } ncc_ctrl_state_t;

  localparam int NCC_ROWS       = 16;
  localparam int NCC_COL_GROUPS = 4;
  localparam int NCC_DESC_WORDS = NCC_ROWS * NCC_COL_GROUPS;
  localparam int NCC_WIN_PIXELS = 640;
  localparam int NCC_FILL       = 16;

endpackage

// File: rtl/ncc_decoder.sv
// Binary-to-one-hot decoder with an enable; output is all-zero when disabled.
module ncc_decoder #(
  parameter int N     = 16,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [N-1:0]     onehot_o
);

  // Drive exactly one bit when enabled, nothing otherwise.
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/ncc_controller.sv
// Sequencer for the 16x16 NCC PE grid: descriptor load, window streaming,
// and valid/ready hand-off of each completed correlation column.
//
// state      | meaning
// IDLE       | waiting for start; all counters clear
// DESC_LOAD  | accepting packed descriptor words, one grid slot per word
// WIN_STREAM | stepping window pixels, presenting result columns
// DONE       | one-cycle done pulse, then back to IDLE
module ncc_controller
  import ncc_pkg::*;
#(
  parameter int NUM_ROWS   = NCC_ROWS,
  parameter int COL_GROUPS = NCC_COL_GROUPS,
  parameter int FILL       = NCC_FILL,
  parameter int WIN_PIXELS = NCC_WIN_PIXELS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  reuse_desc,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  output logic                  load_desc_now,
  output logic [NUM_ROWS-1:0]   desc_row_sel,
  output logic [COL_GROUPS-1:0] desc_col_sel,
  input  logic                  win_valid,
  output logic                  win_ready,
  output logic                  load_win_reg,
  output logic                  load_acc_sum_reg,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int ROW_W  = $clog2(NUM_ROWS);
  localparam int COL_W  = $clog2(COL_GROUPS);
  localparam int DESC_W = ROW_W + COL_W;
  localparam int STEP_W = $clog2(WIN_PIXELS + 1);

  // Word counter wraps from all-ones to zero on the final descriptor word.
  localparam logic [DESC_W-1:0] DESC_LAST = '1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIN_PIXELS);
  // Step k (1-based) produces a result once k >= FILL, i.e. count_before >= FILL-1.
  localparam logic [STEP_W-1:0] FILL_M1   = STEP_W'(FILL - 1);
  // Index of the final result, counted from zero.
  localparam logic [STEP_W-1:0] RES_LAST  = STEP_W'(WIN_PIXELS - FILL);

  ncc_ctrl_state_t   state_q, state_d;
  logic [DESC_W-1:0] desc_cnt_q, desc_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0] res_cnt_q, res_cnt_d;
  logic              res_valid_q, res_valid_d;
  logic              step;
  logic              res_accept;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      desc_cnt_q  <= '0;
      step_cnt_q  <= '0;
      res_cnt_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      desc_cnt_q  <= desc_cnt_d;
      step_cnt_q  <= step_cnt_d;
      res_cnt_q   <= res_cnt_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Next-state, counter updates and handshake outputs.
  always_comb begin
    state_d       = state_q;
    desc_cnt_d    = desc_cnt_q;
    step_cnt_d    = step_cnt_q;
    res_cnt_d     = res_cnt_q;
    res_valid_d   = res_valid_q;
    desc_ready    = 1'b0;
    load_desc_now = 1'b0;
    win_ready     = 1'b0;
    step          = 1'b0;
    res_accept    = 1'b0;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = reuse_desc ? WIN_STREAM : DESC_LOAD;
      end

      DESC_LOAD: begin
        desc_ready    = 1'b1;
        load_desc_now = desc_valid;
        if (desc_valid) begin
          desc_cnt_d = desc_cnt_q + 1'b1;
          if (desc_cnt_q == DESC_LAST) state_d = WIN_STREAM;
        end
      end

      WIN_STREAM: begin
        // A result held under backpressure freezes the grid so accOut stays stable.
        win_ready  = (step_cnt_q != STEP_LAST) && !(res_valid_q && !result_ready);
        step       = win_valid && win_ready;
        res_accept = res_valid_q && result_ready;
        if (res_accept) begin
          res_valid_d = 1'b0;
          res_cnt_d   = res_cnt_q + 1'b1;
          if (res_cnt_q == RES_LAST) state_d = DONE;
        end
        // A step that completes a column re-arms valid even while one is accepted.
        if (step) begin
          step_cnt_d = step_cnt_q + 1'b1;
          if (step_cnt_q >= FILL_M1) res_valid_d = 1'b1;
        end
      end

      DONE: begin
        done        = 1'b1;
        state_d     = IDLE;
        desc_cnt_d  = '0;
        step_cnt_d  = '0;
        res_cnt_d   = '0;
        res_valid_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  assign load_win_reg     = step;
  assign load_acc_sum_reg = step;
  assign result_valid     = res_valid_q;
  assign busy             = (state_q != IDLE);

  ncc_decoder #(.N(NUM_ROWS)) u_row_dec (
    .en_i     (load_desc_now),
    .sel_i    (desc_cnt_q[DESC_W-1:COL_W]),
    .onehot_o (desc_row_sel)
  );

  ncc_decoder #(.N(COL_GROUPS)) u_col_dec (
    .en_i     (load_desc_now),
    .sel_i    (desc_cnt_q[COL_W-1:0]),
    .onehot_o (desc_col_sel)
  );

endmodule

// File: tb/tb_ncc_controller.sv
// Directed bench for ncc_controller with a transaction-level reference model.
module tb_ncc_controller;
  import ncc_pkg::*;

  localparam int TB_FILL = 16;
  localparam int RESULTS = NCC_WIN_PIXELS - TB_FILL + 1;
  localparam int PH_IDLE = 0, PH_DESC = 1, PH_WIN = 2, PH_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, reuse_desc = 1'b0;
  logic        desc_valid = 1'b0, desc_ready, load_desc_now;
  logic [15:0] desc_row_sel;
  logic [3:0]  desc_col_sel;
  logic        win_valid = 1'b0, win_ready, load_win_reg, load_acc_sum_reg;
  logic        result_valid, result_ready = 1'b0;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  ncc_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .reuse_desc       (reuse_desc),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .load_desc_now    (load_desc_now),
    .desc_row_sel     (desc_row_sel),
    .desc_col_sel     (desc_col_sel),
    .win_valid        (win_valid),
    .win_ready        (win_ready),
    .load_win_reg     (load_win_reg),
    .load_acc_sum_reg (load_acc_sum_reg),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pass phase plus counts of words, steps and delivered results.
  int m_phase = PH_IDLE, m_words = 0, m_steps = 0, m_deliv = 0;

  always @(negedge clk) begin : model
    int  produced, pending, e_row, e_col;
    bit  e_rv, e_dr, e_ld, e_wr, e_step;
    if (!rst_n) begin
      m_phase = PH_IDLE; m_words = 0; m_steps = 0; m_deliv = 0;
    end
    produced = (m_steps >= TB_FILL) ? m_steps - TB_FILL + 1 : 0;
    pending  = produced - m_deliv;
    e_rv   = (m_phase == PH_WIN) && (pending > 0);
    e_dr   = (m_phase == PH_DESC);
    e_ld   = e_dr && desc_valid;
    e_row  = e_ld ? (1 << (m_words / 4)) : 0;
    e_col  = e_ld ? (1 << (m_words % 4)) : 0;
    e_wr   = (m_phase == PH_WIN) && (m_steps < NCC_WIN_PIXELS) && !(e_rv && !result_ready);
    e_step = e_wr && win_valid;

    chk("busy", 32'(busy), 32'(m_phase != PH_IDLE));
    chk("done", 32'(done), 32'(m_phase == PH_DONE));
    chk("desc_ready", 32'(desc_ready), 32'(e_dr));
    chk("load_desc_now", 32'(load_desc_now), 32'(e_ld));
    chk("desc_row_sel", 32'(desc_row_sel), e_row);
    chk("desc_col_sel", 32'(desc_col_sel), e_col);
    chk("win_ready", 32'(win_ready), 32'(e_wr));
    chk("load_win_reg", 32'(load_win_reg), 32'(e_step));
    chk("load_acc_sum_reg", 32'(load_acc_sum_reg), 32'(e_step));
    chk("result_valid", 32'(result_valid), 32'(e_rv));

    if (rst_n) begin
      case (m_phase)
        PH_IDLE: if (start) m_phase = reuse_desc ? PH_WIN : PH_DESC;
        PH_DESC: if (e_ld) begin
          m_words++;
          if (m_words == NCC_DESC_WORDS) begin m_words = 0; m_phase = PH_WIN; end
        end
        PH_WIN: begin
          if (e_rv && result_ready) m_deliv++;
          if (e_step) m_steps++;
          if (e_rv && result_ready && m_deliv == RESULTS) m_phase = PH_DONE;
        end
        default: begin m_phase = PH_IDLE; m_words = 0; m_steps = 0; m_deliv = 0; end
      endcase
    end
  end

  // Event tallies taken from the DUT handshakes.
  int n_busy = 0, n_done = 0, n_res = 0, n_desc_hs = 0, n_steps = 0;
  int first_rv_steps = -1;
  bit rv_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) n_busy++;
      if (done) n_done++;
      if (result_valid && result_ready) n_res++;
      if (load_desc_now) n_desc_hs++;
      if (result_valid && !rv_seen) begin rv_seen = 1'b1; first_rv_steps = n_steps; end
      if (load_win_reg) n_steps++;
    end
  end

  initial begin
    int w, gap, guard, cyc, stall_left;
    int b_busy, b_done, b_res, b_desc;
    bit got_done, stall_started, release_nxt;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_win_ready", 32'(win_ready), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pass A: full descriptor load with a 3-cycle gap after word 10, then no-backpressure stream.
    b_busy = n_busy; b_done = n_done; b_res = n_res; b_desc = n_desc_hs;
    start = 1'b1; reuse_desc = 1'b0; win_valid = 1'b1; result_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0; gap = 0; guard = 0;
    while (w < 64 && guard < 200) begin
      desc_valid = (gap == 0);
      @(negedge clk);
      if (guard == 0) begin
        chk("a_busy_after_start", 32'(busy), 1);
        chk("a_desc_ready_after_start", 32'(desc_ready), 1);
      end
      if (desc_valid) begin
        case (w)
          0:  begin chk("w0_row", 32'(desc_row_sel), 32'h0001);  chk("w0_col", 32'(desc_col_sel), 32'h1); end
          5:  begin chk("w5_row", 32'(desc_row_sel), 32'h0002);  chk("w5_col", 32'(desc_col_sel), 32'h2); end
          11: begin chk("w11_row", 32'(desc_row_sel), 32'h0004); chk("w11_col", 32'(desc_col_sel), 32'h8); end
          63: begin
            chk("w63_row", 32'(desc_row_sel), 32'h8000);
            chk("w63_col", 32'(desc_col_sel), 32'h8);
            chk("w63_win_ready", 32'(win_ready), 0);
          end
          default: ;
        endcase
        w++;
        if (w == 11) gap = 3;
      end else begin
        chk("gap_load_desc_now", 32'(load_desc_now), 0);
        chk("gap_row_sel", 32'(desc_row_sel), 0);
        chk("gap_col_sel", 32'(desc_col_sel), 0);
        gap--;
      end
      guard++;
      @(posedge clk); #1;
    end
    desc_valid = 1'b0;
    chk("a_desc_timeout", 32'(w), 64);
    @(negedge clk);
    chk("a_win_ready_after_w63", 32'(win_ready), 1);
    got_done = 1'b0; guard = 0;
    while (!got_done && guard < 2000) begin
      @(negedge clk);
      got_done = done;
      guard++;
    end
    chk("a_done_timeout", 32'(got_done), 1);
    @(posedge clk); #1;
    chk("a_first_rv_after_step16", 32'(first_rv_steps), 16);
    chk("a_result_count", 32'(n_res - b_res), 625);
    chk("a_done_pulses", 32'(n_done - b_done), 1);
    chk("a_desc_handshakes", 32'(n_desc_hs - b_desc), 64);
    chk("a_busy_cycles", 32'(n_busy - b_busy), 709);
    @(negedge clk);
    chk("a_idle_after", 32'(busy), 0);

    // Pass B: reuse descriptors, irregular traffic, 4-cycle stall on result 5, stray start.
    @(posedge clk); #1;
    b_done = n_done; b_res = n_res; b_desc = n_desc_hs;
    start = 1'b1; reuse_desc = 1'b1; win_valid = 1'b0; result_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reuse_desc = 1'b0;
    @(negedge clk);
    chk("b_busy", 32'(busy), 1);
    chk("b_desc_ready", 32'(desc_ready), 0);
    chk("b_win_ready", 32'(win_ready), 1);
    cyc = 0; stall_left = 0; stall_started = 1'b0; release_nxt = 1'b0; got_done = 1'b0;
    while (!got_done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start        = (cyc == 100);
      win_valid    = (cyc % 7 != 3);
      result_ready = (cyc % 11 != 5);
      if (!stall_started && result_valid && (n_res - b_res) == 4) begin
        stall_started = 1'b1;
        stall_left = 4;
      end
      if (stall_left > 0) result_ready = 1'b0;
      else if (release_nxt) begin result_ready = 1'b1; win_valid = 1'b1; end
      @(negedge clk);
      if (stall_left > 0) begin
        chk("stall_win_ready", 32'(win_ready), 0);
        chk("stall_load_win", 32'(load_win_reg), 0);
        chk("stall_load_acc", 32'(load_acc_sum_reg), 0);
        chk("stall_result_valid", 32'(result_valid), 1);
        stall_left--;
        if (stall_left == 0) release_nxt = 1'b1;
      end else if (release_nxt) begin
        chk("release_win_ready", 32'(win_ready), 1);
        chk("release_load_win", 32'(load_win_reg), 1);
        chk("release_result_valid", 32'(result_valid), 1);
        release_nxt = 1'b0;
      end
      if (cyc == 101) begin
        chk("stray_start_desc_ready", 32'(desc_ready), 0);
        chk("stray_start_busy", 32'(busy), 1);
      end
      got_done = done;
    end
    start = 1'b0;
    chk("b_done_timeout", 32'(got_done), 1);
    chk("b_stall_seen", 32'(stall_started), 1);
    @(posedge clk); #1;
    chk("b_result_count", 32'(n_res - b_res), 625);
    chk("b_done_pulses", 32'(n_done - b_done), 1);
    chk("b_desc_handshakes", 32'(n_desc_hs - b_desc), 0);

    // Pass C: asynchronous reset in the middle of streaming.
    start = 1'b1; reuse_desc = 1'b1; win_valid = 1'b1; result_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reuse_desc = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("c_rv_before_reset", 32'(result_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("c_rst_busy", 32'(busy), 0);
    chk("c_rst_win_ready", 32'(win_ready), 0);
    chk("c_rst_result_valid", 32'(result_valid), 0);
    chk("c_rst_load_win", 32'(load_win_reg), 0);
    chk("c_rst_desc_ready", 32'(desc_ready), 0);
    chk("c_rst_done", 32'(done), 0);
    @(posedge clk); #1;
    win_valid = 1'b0;
    rst_n = 1'b1;
    start = 1'b1; reuse_desc = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; desc_valid = 1'b1;
    @(negedge clk);
    chk("c_desc_ready", 32'(desc_ready), 1);
    chk("c_w0_row", 32'(desc_row_sel), 32'h0001);
    chk("c_w0_col", 32'(desc_col_sel), 32'h1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ncc_controller.md
# ncc_controller

Sequencing controller for the 16x16 NCC processing-element grid. It accepts a start command, then streams 64 packed descriptor words into the grid: 16 rows x 4 column groups, 4 pixels per word. It then steps window pixels through the systolic array and hands each completed correlation column to downstream logic under a valid/ready handshake. It sits between the descriptor/window memories and the PE grid, and owns every grid load strobe.

## Interface
Parameters:
- NUM_ROWS, 16, PE rows; one-hot row select width
- COL_GROUPS, 4, column groups per row; one descriptor word per group
- FILL, 16, window steps before the first valid result (PEs per row)
- WIN_PIXELS, 640, window pixels per correlation pass

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- reuse_desc  in  1  sampled with start; 1 = skip descriptor load and keep grid descriptors
- desc_valid  in  1  descriptor word available
- desc_ready  out  1  controller accepts descriptor word
- load_desc_now  out  1  descriptor register write strobe to grid
- desc_row_sel  out  NUM_ROWS  one-hot row select
- desc_col_sel  out  COL_GROUPS  one-hot column-group select
- win_valid  in  1  window pixel available
- win_ready  out  1  controller accepts window pixel
- load_win_reg  out  1  window shift strobe to grid
- load_acc_sum_reg  out  1  accumulator update strobe to grid
- result_valid  out  1  grid accOut column holds a valid result
- result_ready  in  1  downstream accepts result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of pass

## Operation
- States: IDLE, DESC_LOAD, WIN_STREAM, DONE.
- Transitions:
  - IDLE -> DESC_LOAD on start & !reuse_desc.
  - IDLE -> WIN_STREAM on start & reuse_desc.
  - start outside IDLE is ignored.
- DESC_LOAD:
  - desc_ready = 1.
  - load_desc_now = desc_valid & desc_ready (combinational).
  - 6-bit word counter: low 2 bits = column group, high 4 bits = row.
  - Word n drives desc_row_sel = 1<<(n/4) and desc_col_sel = 1<<(n%4).
  - The counter advances only on an accepted word.
  - Selects are all-zero whenever load_desc_now = 0.
  - After the 64th accepted word (counter wraps 63->0), go to WIN_STREAM.
- WIN_STREAM:
  - win_ready = !(result_valid & !result_ready).
  - step = win_valid & win_ready; load_win_reg = load_acc_sum_reg = step (combinational, same cycle).
  - Step counter counts 0..WIN_PIXELS.
  - result_valid is registered: set the cycle after accepted step k when k >= FILL; cleared on result_valid & result_ready unless a new step sets it that same cycle (set wins).
  - After WIN_PIXELS steps, win_ready = 0.
  - When the final result (number WIN_PIXELS-FILL+1, i.e. 625 by default) is accepted, go to DONE.
- DONE: done = 1 for one cycle, then IDLE. All counters clear on entry to IDLE.
- Reset (any state, asynchronous): state IDLE; all counters 0; all outputs 0. Descriptor contents held in the grid are not guaranteed valid afterwards, so the next start must use reuse_desc = 0.

## Timing
- start accepted at edge t: busy = 1 from t+1; desc_ready = 1 from t+1.
- Descriptor phase takes 64 cycles minimum with desc_valid held high.
- win_ready rises the cycle after the 64th descriptor handshake.
- Strobes (load_desc_now, load_win_reg, load_acc_sum_reg) are combinational from the handshake: zero latency, one cycle per accepted item.
- First result_valid: one cycle after the 16th step.
- Without backpressure, a pass takes 64 + WIN_PIXELS + 2 cycles from start.
- Backpressure: while result_valid & !result_ready, no strobes fire and the grid is frozen; this keeps accOut stable.
- Simultaneous accept and new step: result_valid stays 1 and the next column is presented the following cycle.

## Structure
- Package ncc_pkg holds:
  - state enum ncc_ctrl_state_t {IDLE, DESC_LOAD, WIN_STREAM, DONE};
  - constants NCC_ROWS = 16, NCC_COL_GROUPS = 4, NCC_DESC_WORDS = 64, NCC_WIN_PIXELS = 640.
- Reuse the existing decoder module for both one-hot selects (gated by load_desc_now).
- No new sub-module; the counters are inline.

## Test plan
- Reset: assert rst_n = 0 mid-WIN_STREAM -> all outputs 0 immediately; state IDLE; the next start with reuse_desc = 0 enters DESC_LOAD.
- Descriptor load, no stalls: 64 words -> word 0 gives row_sel = 0x0001, col_sel = 0x1; word 5 gives 0x0002/0x2; word 63 gives 0x8000/0x8; win_ready = 1 the cycle after word 63.
- Descriptor gaps: desc_valid low for 3 cycles after word 10 -> load_desc_now = 0, selects 0, and word 11 still maps to row 2, col 3.
- Window pass, no backpressure: 640 pixels -> result_valid first seen the cycle after step 16; exactly 625 results; done pulses once; IDLE after.
- Backpressure: result_ready = 0 for 4 cycles on result 5 -> win_ready = 0, no load strobes, result_valid held; the stream resumes on the release cycle.
- reuse_desc = 1 start -> IDLE to WIN_STREAM directly, zero descriptor handshakes; start pulsed while busy -> ignored.
